wb_select_stage: RTL and testbench

- Parametrised MEM/WB pipeline register with write-back selection logic.
- Captures one instruction's result sources and control, then presents the register-file write port (address, data, enable) one cycle later.
- Adds stall/flush handling, reserved-code protection, $0 write suppression and a retired-instruction counter.
- Sits between the data-memory stage and the register file in the pipelined core.

---
 rtl/wb_select_stage.sv | 145 ++++++++++++++
 tb/tb_wb_select_stage.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/wb_select_stage.sv
// MEM/WB pipeline register with write-back address/data selection, one-shot write on stall and retire counter.
// Optional WB_LOAD_EXT_EN adds sub-word load extraction (load_type/byte_off); requires DATA_W=32.
module wb_select_stage #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 5,
  parameter int unsigned PC_STEP = 4,
  parameter int unsigned RA_ADDR = 31,
  parameter int unsigned COUNT_W = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  input  logic               stall,
  input  logic               flush,
  input  logic               reg_write,
  input  logic [1:0]         reg_dst,
  input  logic [1:0]         mem_back,
  input  logic [ADDR_W-1:0]  rt,
  input  logic [ADDR_W-1:0]  rd,
  input  logic [DATA_W-1:0]  alu_result,
  input  logic [DATA_W-1:0]  dm_result,
  input  logic [DATA_W-1:0]  pc,
`ifdef WB_LOAD_EXT_EN
  input  logic [2:0]         load_type,
  input  logic [1:0]         byte_off,
`endif
  output logic               wb_valid,
  output logic               wb_we,
  output logic [ADDR_W-1:0]  wb_addr,
  output logic [DATA_W-1:0]  wb_data,
  output logic [COUNT_W-1:0] retire_cnt
);

  logic              valid_q;
  logic              fired_q;
  logic              reg_write_q;
  logic [1:0]        reg_dst_q;
  logic [1:0]        mem_back_q;
  logic [ADDR_W-1:0] rt_q;
  logic [ADDR_W-1:0] rd_q;
  logic [DATA_W-1:0] alu_q;
  logic [DATA_W-1:0] dm_q;
  logic [DATA_W-1:0] pc_q;
  logic [DATA_W-1:0] dm_sel;
  logic              present;

  // An entry is "presented" only in its first cycle; later stalled cycles are replays.
  assign present = valid_q & ~fired_q;

  // Entry register: flush beats stall; stall holds everything but marks the entry as fired.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q     <= 1'b0;
      fired_q     <= 1'b0;
      reg_write_q <= 1'b0;
      reg_dst_q   <= 2'b00;
      mem_back_q  <= 2'b00;
      rt_q        <= '0;
      rd_q        <= '0;
      alu_q       <= '0;
      dm_q        <= '0;
      pc_q        <= '0;
    end else if (flush) begin
      valid_q <= 1'b0;
      fired_q <= 1'b0;
    end else if (stall) begin
      fired_q <= fired_q | valid_q;
    end else begin
      valid_q     <= in_valid;
      fired_q     <= 1'b0;
      reg_write_q <= reg_write;
      reg_dst_q   <= reg_dst;
      mem_back_q  <= mem_back;
      rt_q        <= rt;
      rd_q        <= rd;
      alu_q       <= alu_result;
      dm_q        <= dm_result;
      pc_q        <= pc;
    end
  end

`ifdef WB_LOAD_EXT_EN
  logic [2:0] load_type_q;
  logic [1:0] byte_off_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      load_type_q <= 3'b000;
      byte_off_q  <= 2'b00;
    end else if (!flush && !stall) begin
      load_type_q <= load_type;
      byte_off_q  <= byte_off;
    end
  end

  // Sub-word extraction of the loaded word; unknown load types behave as lw.
  always_comb begin
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    case (byte_off_q)
      2'd0:    byte_v = dm_q[7:0];
      2'd1:    byte_v = dm_q[15:8];
      2'd2:    byte_v = dm_q[23:16];
      default: byte_v = dm_q[31:24];
    endcase
    half_v = byte_off_q[1] ? dm_q[31:16] : dm_q[15:0];
    case (load_type_q)
      3'b001:  dm_sel = {{24{byte_v[7]}}, byte_v};
      3'b010:  dm_sel = {24'd0, byte_v};
      3'b011:  dm_sel = {{16{half_v[15]}}, half_v};
      3'b100:  dm_sel = {16'd0, half_v};
      default: dm_sel = dm_q;
    endcase
  end
`else
  assign dm_sel = dm_q;
`endif

  // Write-back address/data selection; reserved codes give zero.
  always_comb begin
    case (reg_dst_q)
      2'b00:   wb_addr = rt_q;
      2'b01:   wb_addr = rd_q;
      2'b10:   wb_addr = ADDR_W'(RA_ADDR);
      default: wb_addr = '0;
    endcase
    case (mem_back_q)
      2'b00:   wb_data = alu_q;
      2'b01:   wb_data = dm_sel;
      2'b10:   wb_data = pc_q + DATA_W'(PC_STEP);
      default: wb_data = '0;
    endcase
  end

  assign wb_valid = valid_q;
  assign wb_we    = present & reg_write_q & (reg_dst_q != 2'b11) &
                    (mem_back_q != 2'b11) & (wb_addr != '0);

  // Retire counter: one count per presented entry, including non-writing ones.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       retire_cnt <= '0;
    else if (present) retire_cnt <= retire_cnt + COUNT_W'(1);
  end

endmodule

// File: tb/tb_wb_select_stage.sv
// Self-checking bench for wb_select_stage: directed vector table plus stall/flush/reset sequences.
module tb_wb_select_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, stall, flush, reg_write;
  logic [1:0]  reg_dst, mem_back;
  logic [4:0]  rt, rd;
  logic [31:0] alu_result, dm_result, pc;
  logic [2:0]  load_type;
  logic [1:0]  byte_off;
  logic        wb_valid, wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic [31:0] retire_cnt;

  int checks = 0;
  int errors = 0;
  int cnt    = 0;

  always #5 clk = ~clk;

  wb_select_stage dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .stall(stall), .flush(flush),
    .reg_write(reg_write), .reg_dst(reg_dst), .mem_back(mem_back), .rt(rt), .rd(rd),
    .alu_result(alu_result), .dm_result(dm_result), .pc(pc),
`ifdef WB_LOAD_EXT_EN
    .load_type(load_type), .byte_off(byte_off),
`endif
    .wb_valid(wb_valid), .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .retire_cnt(retire_cnt)
  );

  typedef struct {
    logic        iv, rw;
    logic [1:0]  dst, mb;
    logic [4:0]  rt, rd;
    logic [31:0] alu, dm, pc;
    logic [2:0]  lt;
    logic [1:0]  bo;
    logic        ev, ewe;
    logic [4:0]  eaddr;
    logic [31:0] edata;
  } vec_t;

`ifdef WB_LOAD_EXT_EN
  localparam int NV = 13;
`else
  localparam int NV = 9;
`endif
  vec_t vecs [NV];

  function automatic vec_t mk(logic iv, logic rw, logic [1:0] dst, logic [1:0] mb,
                              logic [4:0] rt_v, logic [4:0] rd_v, logic [31:0] alu,
                              logic [31:0] dm, logic [31:0] pc_v, logic [2:0] lt,
                              logic [1:0] bo, logic ev, logic ewe, logic [4:0] eaddr,
                              logic [31:0] edata);
    vec_t v;
    v.iv = iv; v.rw = rw; v.dst = dst; v.mb = mb; v.rt = rt_v; v.rd = rd_v;
    v.alu = alu; v.dm = dm; v.pc = pc_v; v.lt = lt; v.bo = bo;
    v.ev = ev; v.ewe = ewe; v.eaddr = eaddr; v.edata = edata;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic ev, input logic ewe,
                         input logic [4:0] ea, input logic [31:0] ed);
    chk({tag, ".wb_valid"}, 64'(wb_valid), 64'(ev));
    chk({tag, ".wb_we"}, 64'(wb_we), 64'(ewe));
    chk({tag, ".wb_addr"}, 64'(wb_addr), 64'(ea));
    chk({tag, ".wb_data"}, 64'(wb_data), 64'(ed));
    chk({tag, ".retire_cnt"}, 64'(retire_cnt), 64'(cnt));
  endtask

  task automatic drive(input vec_t v);
    in_valid = v.iv; reg_write = v.rw; reg_dst = v.dst; mem_back = v.mb;
    rt = v.rt; rd = v.rd; alu_result = v.alu; dm_result = v.dm; pc = v.pc;
    load_type = v.lt; byte_off = v.bo;
  endtask

  task automatic drive_random();
    in_valid = 1'($urandom); reg_write = 1'($urandom); reg_dst = 2'($urandom);
    mem_back = 2'($urandom); rt = 5'($urandom); rd = 5'($urandom);
    alu_result = $urandom; dm_result = $urandom; pc = $urandom;
    load_type = 3'($urandom); byte_off = 2'($urandom);
  endtask

  initial begin
    vecs[0] = mk(1, 1, 2'b01, 2'b00, 5'd0, 5'd8, 32'h1234, 32'h0, 32'h0, 3'd0, 2'd0,
                 1, 1, 5'd8, 32'h0000_1234);
    vecs[1] = mk(1, 1, 2'b10, 2'b10, 5'd1, 5'd2, 32'h0, 32'h0, 32'h0000_3000, 3'd0, 2'd0,
                 1, 1, 5'd31, 32'h0000_3004);
    vecs[2] = mk(1, 1, 2'b10, 2'b10, 5'd1, 5'd2, 32'h0, 32'h0, 32'hFFFF_FFFC, 3'd0, 2'd0,
                 1, 1, 5'd31, 32'h0000_0000);
    vecs[3] = mk(1, 1, 2'b00, 2'b01, 5'd5, 5'd9, 32'h0, 32'hDEAD_BEEF, 32'h0, 3'd0, 2'd0,
                 1, 1, 5'd5, 32'hDEAD_BEEF);
    vecs[4] = mk(1, 1, 2'b01, 2'b00, 5'd3, 5'd0, 32'h77, 32'h0, 32'h0, 3'd0, 2'd0,
                 1, 0, 5'd0, 32'h77);
    vecs[5] = mk(1, 1, 2'b11, 2'b00, 5'd3, 5'd9, 32'h55, 32'h0, 32'h0, 3'd0, 2'd0,
                 1, 0, 5'd0, 32'h55);
    vecs[6] = mk(1, 1, 2'b01, 2'b11, 5'd3, 5'd9, 32'h66, 32'h99, 32'h40, 3'd0, 2'd0,
                 1, 0, 5'd9, 32'h0);
    vecs[7] = mk(0, 1, 2'b01, 2'b00, 5'd3, 5'd9, 32'hA5A5, 32'h0, 32'h0, 3'd0, 2'd0,
                 0, 0, 5'd9, 32'hA5A5);
    vecs[8] = mk(1, 0, 2'b01, 2'b00, 5'd3, 5'd4, 32'h4444, 32'h0, 32'h0, 3'd0, 2'd0,
                 1, 0, 5'd4, 32'h4444);
`ifdef WB_LOAD_EXT_EN
    vecs[9]  = mk(1, 1, 2'b01, 2'b01, 5'd0, 5'd10, 32'h0, 32'h80FF_7F01, 32'h0, 3'b001, 2'd3,
                  1, 1, 5'd10, 32'hFFFF_FF80);
    vecs[10] = mk(1, 1, 2'b01, 2'b01, 5'd0, 5'd10, 32'h0, 32'h80FF_7F01, 32'h0, 3'b010, 2'd3,
                  1, 1, 5'd10, 32'h0000_0080);
    vecs[11] = mk(1, 1, 2'b01, 2'b01, 5'd0, 5'd10, 32'h0, 32'h80FF_7F01, 32'h0, 3'b011, 2'd2,
                  1, 1, 5'd10, 32'hFFFF_80FF);
    vecs[12] = mk(1, 1, 2'b01, 2'b01, 5'd0, 5'd10, 32'h0, 32'h80FF_7F01, 32'h0, 3'b100, 2'd0,
                  1, 1, 5'd10, 32'h0000_7F01);
`endif

    // Reset held low with random inputs.
    reset = 1'b0; stall = 1'b0; flush = 1'b0;
    drive_random();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk_out($sformatf("reset%0d", i), 0, 0, 5'd0, 32'd0);
      @(negedge clk);
      drive_random();
      stall = 1'($urandom); flush = 1'($urandom);
    end
    stall = 1'b0; flush = 1'b0;
    reset = 1'b1;

    // Vector table: one capture per cycle, counter lags by one presentation cycle.
    for (int k = 0; k < NV; k++) begin
      @(negedge clk);
      drive(vecs[k]);
      @(posedge clk); #1;
      chk_out($sformatf("vec%0d", k), vecs[k].ev, vecs[k].ewe, vecs[k].eaddr, vecs[k].edata);
      if (vecs[k].iv) cnt++;
    end

    // Stall for 3 cycles: write once, valid throughout, count once.
    @(negedge clk);
    drive(mk(1, 1, 2'b00, 2'b01, 5'd5, 5'd9, 32'h0, 32'hDEAD_BEEF, 32'h0, 3'd0, 2'd0,
             0, 0, 5'd0, 32'd0));
    @(posedge clk); #1;
    chk_out("stall_first", 1, 1, 5'd5, 32'hDEAD_BEEF);
    cnt++;
    @(negedge clk);
    stall = 1'b1;
    drive(mk(1, 1, 2'b01, 2'b00, 5'd7, 5'd12, 32'h1111, 32'h2222, 32'h0, 3'd0, 2'd0,
             0, 0, 5'd0, 32'd0));
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk_out($sformatf("stall_hold%0d", i), 1, 0, 5'd5, 32'hDEAD_BEEF);
    end

    // Flush and stall together drop the held entry.
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk); #1;
    chk("flush_stall.wb_valid", 64'(wb_valid), 64'(0));
    chk("flush_stall.wb_we", 64'(wb_we), 64'(0));
    chk("flush_stall.retire_cnt", 64'(retire_cnt), 64'(cnt));

    // Flush during first presentation: write and count still happen.
    @(negedge clk);
    flush = 1'b0; stall = 1'b0;
    drive(mk(1, 1, 2'b01, 2'b00, 5'd0, 5'd7, 32'hABCD, 32'h0, 32'h0, 3'd0, 2'd0,
             0, 0, 5'd0, 32'd0));
    @(posedge clk); #1;
    chk_out("flush_first", 1, 1, 5'd7, 32'h0000_ABCD);
    cnt++;
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk); #1;
    chk("flush_after.wb_valid", 64'(wb_valid), 64'(0));
    chk("flush_after.wb_we", 64'(wb_we), 64'(0));
    chk("flush_after.retire_cnt", 64'(retire_cnt), 64'(cnt));

    // Reset asserted mid-stall clears everything immediately.
    @(negedge clk);
    flush = 1'b0;
    drive(mk(1, 1, 2'b01, 2'b00, 5'd0, 5'd6, 32'h6666, 32'h0, 32'h0, 3'd0, 2'd0,
             0, 0, 5'd0, 32'd0));
    @(posedge clk); #1;
    chk_out("pre_rst", 1, 1, 5'd6, 32'h6666);
    cnt++;
    @(negedge clk);
    stall = 1'b1;
    @(posedge clk); #1;
    chk_out("pre_rst_stall", 1, 0, 5'd6, 32'h6666);
    #2 reset = 1'b0;
    #1;
    cnt = 0;
    chk_out("mid_rst", 0, 0, 5'd0, 32'd0);
    @(negedge clk);
    reset = 1'b1; stall = 1'b0;
    drive(mk(1, 1, 2'b01, 2'b00, 5'd0, 5'd3, 32'h3333, 32'h0, 32'h0, 3'd0, 2'd0,
             0, 0, 5'd0, 32'd0));
    @(posedge clk); #1;
    chk_out("post_rst", 1, 1, 5'd3, 32'h3333);
    cnt++;
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_cnt", 64'(retire_cnt), 64'(cnt));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
